sel_dispatch: RTL and testbench

SEL_DISPATCH -- requirements
Module: sel_dispatch

---
 rtl/sel_dispatch_pkg.sv | 39 +++
 rtl/sel_decode.sv | 21 ++
 rtl/sel_dispatch.sv | 115 +++++++++++
 tb/tb_sel_dispatch.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sel_dispatch_pkg.sv
// Shared types and decode constants for the opcode classifier.
// Counter feature is enabled by defining SEL_DISPATCH_CNT_EN.
package sel_dispatch_pkg;

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_ALU     = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_ILLEGAL = 3'd7
  } cls_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  // Each class matches when (op & MASK) == VAL; earlier entries take priority.
  localparam logic [7:0] MASK_NOP    = 8'hFF;
  localparam logic [7:0] VAL_NOP     = 8'h00;
  localparam logic [7:0] MASK_ALU    = 8'h80;
  localparam logic [7:0] VAL_ALU     = 8'h80;
  localparam logic [7:0] MASK_LOAD   = 8'hC0;
  localparam logic [7:0] VAL_LOAD    = 8'h40;
  localparam logic [7:0] MASK_STORE  = 8'hE0;
  localparam logic [7:0] VAL_STORE   = 8'h20;
  localparam logic [7:0] MASK_BRANCH = 8'hF0;
  localparam logic [7:0] VAL_BRANCH  = 8'h10;

  localparam int NUM_CNT = 6;

  // ILLEGAL (7) is packed into counter slot 5 so the bank stays dense.
  function automatic logic [2:0] cnt_index(input cls_e cls);
    return (cls == CLS_ILLEGAL) ? 3'd5 : cls;
  endfunction

endpackage

// File: rtl/sel_decode.sv
// Combinational first-match opcode classifier.
module sel_decode
  import sel_dispatch_pkg::*;
(
  input  logic [7:0] op,
  output cls_e       cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    casez (1'b1)
      ((op & MASK_NOP)    == VAL_NOP):    cls = CLS_NOP;
      ((op & MASK_ALU)    == VAL_ALU):    cls = CLS_ALU;
      ((op & MASK_LOAD)   == VAL_LOAD):   cls = CLS_LOAD;
      ((op & MASK_STORE)  == VAL_STORE):  cls = CLS_STORE;
      ((op & MASK_BRANCH) == VAL_BRANCH): cls = CLS_BRANCH;
      default:                            cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/sel_dispatch.sv
// Opcode dispatcher: classifies each accepted opcode and holds it on a valid/ready output.
// Define SEL_DISPATCH_CNT_EN to add per-class saturating hit counters.
module sel_dispatch
  import sel_dispatch_pkg::*;
#(
  parameter int OP_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_cls,
  output logic [OP_W-1:0]  out_op,
  output logic             err,
  input  logic             err_clr,
  input  logic [2:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_data,
  input  logic             cnt_clr
);

  state_e state;
  cls_e   dec_cls;
  logic   accept;
  logic   out_xfer;

  sel_decode u_decode (
    .op  (in_op[7:0]),
    .cls (dec_cls)
  );

  assign in_ready = rst_n && (state != ST_ERR) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // ERR blocks input but keeps draining the output so a held result is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_cls   <= 3'd0;
      out_op    <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_cls   <= dec_cls;
            out_op    <= in_op;
            if (dec_cls == CLS_ILLEGAL) begin
              err   <= 1'b1;
              state <= ST_ERR;
            end else begin
              state <= ST_HOLD;
            end
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (out_xfer) begin
            out_valid <= 1'b0;
          end
          if (err_clr) begin
            err   <= 1'b0;
            state <= (out_valid && !out_xfer) ? ST_HOLD : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SEL_DISPATCH_CNT_EN
  logic [CNT_W-1:0] cnt [NUM_CNT];
  logic [2:0]       inc_idx;

  assign inc_idx = cnt_index(dec_cls);

  // Clear beats a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt[i] <= '0;
      end
    end else if (accept && (cnt[inc_idx] != {CNT_W{1'b1}})) begin
      cnt[inc_idx] <= cnt[inc_idx] + 1'b1;
    end
  end

  always_comb begin
    cnt_data = '0;
    case (cnt_sel)
      3'd0:    cnt_data = cnt[0];
      3'd1:    cnt_data = cnt[1];
      3'd2:    cnt_data = cnt[2];
      3'd3:    cnt_data = cnt[3];
      3'd4:    cnt_data = cnt[4];
      3'd7:    cnt_data = cnt[5];
      default: cnt_data = '0;
    endcase
  end
`else
  logic unused_cnt_inputs;

  assign unused_cnt_inputs = ^{cnt_sel, cnt_clr};
  assign cnt_data          = '0;
`endif

endmodule

// File: tb/tb_sel_dispatch.sv
// Self-checking bench for sel_dispatch: directed scenarios then random traffic vs a class-level model.
// Counter checks follow SEL_DISPATCH_CNT_EN; a second instance with CNT_W=2 exercises saturation.
module tb_sel_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [7:0]  in_op = 8'h00;
  logic [2:0]  cnt_sel = 3'd0;

  logic        in_ready, out_valid, err;
  logic [2:0]  out_cls;
  logic [7:0]  out_op;
  logic [15:0] cnt_data;

  logic        sat_in_ready, sat_out_valid, sat_err;
  logic [2:0]  sat_out_cls;
  logic [7:0]  sat_out_op;
  logic [1:0]  sat_cnt_data;

  int checks = 0;
  int errors = 0;

  bit m_valid, m_err;
  int m_cls, m_op;
  int cnt_wide [8];
  int cnt_sat  [8];

  always #5 clk = ~clk;

  sel_dispatch #(.OP_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_cls(out_cls), .out_op(out_op),
    .err(err), .err_clr(err_clr), .cnt_sel(cnt_sel), .cnt_data(cnt_data), .cnt_clr(cnt_clr)
  );

  sel_dispatch #(.OP_W(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready), .in_op(in_op),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_cls(sat_out_cls), .out_op(sat_out_op),
    .err(sat_err), .err_clr(err_clr), .cnt_sel(cnt_sel), .cnt_data(sat_cnt_data), .cnt_clr(cnt_clr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Class from the opcode's leading-one position.
  function automatic int classify(input int op);
    if (op == 0)   return 0;
    if (op >= 128) return 1;
    if (op >= 64)  return 2;
    if (op >= 32)  return 3;
    if (op >= 16)  return 4;
    return 7;
  endfunction

  function automatic int expCount(input int sel, input bit sat);
    if (sel == 5 || sel == 6) return 0;
    return sat ? cnt_sat[sel] : cnt_wide[sel];
  endfunction

  task automatic clearCounts();
    for (int i = 0; i < 8; i++) begin
      cnt_wide[i] = 0;
      cnt_sat[i]  = 0;
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check combinational outputs, advance model.
  task automatic applyStimulus(input bit rn, input bit iv, input int op, input bit ordy,
                               input bit ec, input bit cc, input int sel);
    bit exp_ready, acc, xfer;
    int c;
    @(negedge clk);
    checkOutput("out_valid", out_valid, m_valid);
    checkOutput("out_cls", out_cls, m_cls);
    checkOutput("out_op", out_op, m_op);
    checkOutput("err", err, m_err);
    checkOutput("sat_out_valid", sat_out_valid, m_valid);
    checkOutput("sat_out_cls", sat_out_cls, m_cls);
    checkOutput("sat_out_op", sat_out_op, m_op);
    checkOutput("sat_err", sat_err, m_err);

    rst_n = rn; in_valid = iv; in_op = op[7:0]; out_ready = ordy;
    err_clr = ec; cnt_clr = cc; cnt_sel = sel[2:0];
    #1;
    exp_ready = rn && !m_err && (!m_valid || ordy);
    checkOutput("in_ready", in_ready, exp_ready);
    checkOutput("sat_in_ready", sat_in_ready, exp_ready);
`ifdef SEL_DISPATCH_CNT_EN
    checkOutput("cnt_data", cnt_data, expCount(sel, 1'b0));
    checkOutput("sat_cnt_data", sat_cnt_data, expCount(sel, 1'b1));
`else
    checkOutput("cnt_data", cnt_data, 0);
    checkOutput("sat_cnt_data", sat_cnt_data, 0);
`endif

    if (!rn) begin
      m_valid = 0; m_err = 0; m_cls = 0; m_op = 0;
      clearCounts();
    end else begin
      acc  = iv && exp_ready;
      xfer = m_valid && ordy;
      c    = classify(op & 255);
      if (m_err && ec) m_err = 0;
      if (acc) begin
        m_valid = 1; m_cls = c; m_op = op & 255;
        if (c == 7) m_err = 1;
        if (cnt_wide[c] < 65535) cnt_wide[c]++;
        if (cnt_sat[c] < 3) cnt_sat[c]++;
      end else if (xfer) begin
        m_valid = 0;
      end
      if (cc) clearCounts();
    end
  endtask

  initial begin
    int burst [5];
    int rop;
    burst = '{8'h00, 8'h85, 8'h42, 8'h2F, 8'h1A};
    m_valid = 0; m_err = 0; m_cls = 0; m_op = 0;
    clearCounts();

    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 8'h85, 1, 0, 0, 0);

    // Back-to-back classes 0..4 with the consumer always ready.
    foreach (burst[i]) applyStimulus(1, 1, burst[i], 1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 0, 0, 4);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);

    // Stall: result must stay put while the consumer is not ready.
    applyStimulus(1, 1, 8'h85, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 8'h11, 0, 0, 0, 1);
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_cls", out_cls, 1);
      checkOutput("stall_op", out_op, 8'h85);
      checkOutput("stall_ready", in_ready, 0);
    end
    applyStimulus(1, 0, 0, 1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 0, 0, 1);

    // Illegal opcode, blocked input, then a clear pulse.
    applyStimulus(1, 1, 8'h07, 1, 0, 0, 7);
    applyStimulus(1, 1, 8'h90, 1, 0, 0, 7);
    checkOutput("err_set", err, 1);
    applyStimulus(1, 1, 8'h90, 1, 0, 0, 7);
    applyStimulus(1, 0, 0, 1, 1, 0, 7);
    applyStimulus(1, 1, 8'h91, 1, 0, 0, 7);
    checkOutput("err_cleared", err, 0);

    // err_clr outside ERR is ignored; err_clr with an illegal accept still sets err.
    applyStimulus(1, 1, 8'h40, 1, 1, 0, 2);
    applyStimulus(1, 1, 8'h0F, 1, 1, 0, 7);
    applyStimulus(1, 0, 0, 0, 0, 0, 7);
    applyStimulus(1, 0, 0, 1, 1, 0, 7);

    // Counter reads, clear racing an accept, saturation in the narrow instance.
    applyStimulus(1, 1, 8'hA0, 1, 0, 0, 1);
    applyStimulus(1, 1, 8'hA1, 1, 0, 0, 1);
    applyStimulus(1, 1, 8'hFF, 1, 0, 0, 1);
    applyStimulus(1, 1, 8'h03, 1, 0, 0, 7);
    applyStimulus(1, 0, 0, 1, 1, 0, 1);
    applyStimulus(1, 0, 0, 1, 0, 0, 7);
    applyStimulus(1, 1, 8'h80, 1, 0, 1, 1);
    applyStimulus(1, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 8'hC0 + i, 1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 0, 0, 6);

    // Reset while a result is held and err is set.
    applyStimulus(1, 1, 8'h05, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_err", err, 0);

    for (int n = 0; n < 3000; n++) begin
      rop = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) rop = $urandom_range(0, 15);
      applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), rop,
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 39) == 0), $urandom_range(0, 7));
    end
    applyStimulus(1, 0, 0, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
